seven_segment_scan_decoder: RTL and testbench
=============================================

Name: seven_segment_scan_decoder

Overview:
- Reverse direction of the hex-to-seven-segment encoder: snoops a time-multiplexed seven-segment display drive (shared segment bus plus per-digit enables) and recovers the hex nibble shown on each digit.
- Sits between the display pins and a logic-analyser, self-test or readback register block.
- Filters glitches and scan transitions with a stability window.
- Flags non-hex patterns and reports completed scan frames.

Parameters:
- DIGITS, 4: number of multiplexed digits (1..8).
- STABLE_CYCLES, 4: consecutive clocks a pattern must hold before capture (1..255).
- SEG_ACTIVE_LOW, 0: 1 means segment inputs are inverted before decoding.
- EN_ACTIVE_LOW, 0: 1 means digit_enable inputs are inverted before use.

Ports:
- clock  in  1  system clock, all logic rising-edge.
- reset  in  1  asynchronous, active-high reset.
- segments  in  7  segment bus, bit6=a .. bit0=g, 1=lit after polarity correction.
- digit_enable  in  DIGITS  digit select, one-hot when valid.
- value  out  4*DIGITS  decoded nibbles; digit i occupies [4i+3:4i].
- digit_valid  out  DIGITS  1 means the last capture for that digit was a hex pattern.
- digit_error  out  DIGITS  1 means the last capture for that digit was a non-hex, non-blank pattern.
- update  out  1  one-cycle pulse on any capture.
- frame_done  out  1  one-cycle pulse when every digit has been captured since the last pulse.

Behaviour:
- Reset (asynchronous, active-high): value, digit_valid, digit_error, update, frame_done, synchronisers, run counter and seen mask all clear to 0 immediately and stay 0 while reset is high.
- Input capture: segments and digit_enable pass through a 2-flop synchroniser, then polarity correction.
- Run counter: counts consecutive clocks on which the synchronised {enable, segments} pair is unchanged.
  - Resets on any change.
  - Saturates at STABLE_CYCLES.
- Capture condition: the run counter first reaches STABLE_CYCLES AND the enable is exactly one-hot. Exactly one capture per stable run; holding the pattern longer never re-captures.
- Zero-hot or multi-hot enable: no capture; counting continues, but a run that reaches STABLE_CYCLES while not one-hot is never captured.
- Latency: if the raw inputs change before edge E0 and then hold, outputs and update change at edge E0+1+STABLE_CYCLES (E0+5 at default). update is high for exactly that one cycle.
- Decode table (pattern -> nibble):
  - 1111110->0, 0110000->1, 1101101->2, 1111001->3
  - 0110011->4, 1011011->5, 1011111->6, 1110000->7
  - 1111111->8, 1111011->9, 1110111->A, 0011111->B
  - 1001110->C, 0111101->D, 1001111->E, 1000111->F
- Capture on digit i:
  - Hex pattern: nibble i <= decoded value; digit_valid[i]=1; digit_error[i]=0.
  - Blank (0000000): digit_valid[i]=0; digit_error[i]=0; nibble unchanged.
  - Any other pattern: digit_valid[i]=0; digit_error[i]=1; nibble unchanged.
  - Other digits' outputs are untouched.
- Seen mask: bit i set on any capture of digit i (hex, blank or error).
  - When the mask would become all-ones, frame_done pulses on the same cycle as that update, and the mask clears to 0 instead. The completing capture does not count toward the next frame.
- Reset mid-run: the partial run is discarded. After release, a held pattern needs the full latency again, measured from the first edge after release.

Test Plan:
1. Hold reset 3 cycles with arbitrary inputs -> all outputs 0; release with inputs idle (enable=0000) -> outputs stay 0, no update.
2. enable=0010, segments=1101101 set before E0 and held 12 cycles -> at E0+5: value[7:4]=2, digit_valid=0010, update high exactly 1 cycle; no further update.
3. enable=0001, segments=0110000 held 3 cycles, then 1111110 held 8 cycles -> no capture of 1; value[3:0]=0 at 5 cycles after the second change, single update.
4. Scan digits 0..3 with patterns C,3,5,A (8 cycles each, 1 cycle all-off gap between digits) -> value=16'hA53C, digit_valid=1111; frame_done pulses with the digit-3 update only. Repeat the scan and step through all 16 patterns across frames -> every nibble decodes correctly.
5. Digit 0: capture 7, then pattern 1010101 -> digit_error[0]=1, digit_valid[0]=0, value[3:0]=7. Then 0000000 -> digit_error[0]=0, digit_valid[0]=0, value[3:0]=7.
6. enable=0110 held 10 cycles -> no update. Then a valid run is interrupted by reset at E0+3 -> outputs 0 at once; with inputs held, capture occurs 5 cycles after the first edge following release.

Source files
------------

// File: rtl/seven_segment_scan_decoder.sv
// ============================================================================
// seven_segment_scan_decoder
//
// Watches a time-multiplexed seven-segment display drive and works out which
// hex digit each display position is showing. This is the reverse of a
// hex-to-seven-segment encoder. Typical users are a logic-analyser front end,
// a self-test block or a readback register block sitting on the display pins.
//
// How it works:
//   * The segment bus and the digit enables first pass through a 2-flop
//     synchroniser. Their polarity is then corrected so that 1 always means
//     "segment lit" and "digit selected".
//   * A run counter counts consecutive clocks on which the synchronised
//     {enable, segments} pair stays the same. It restarts on any change and
//     stops counting (saturates) at STABLE_CYCLES.
//   * A capture happens only on the clock where the run first reaches
//     STABLE_CYCLES, and only if the enable is exactly one-hot. So scan
//     transitions and glitches are ignored, and a pattern that is held for a
//     long time is still captured only once.
//   * Each capture updates the selected digit: a hex pattern, blank, or error.
//     When every digit has been captured since the last frame, frame_done
//     pulses.
//
// Parameters:
//   DIGITS          number of multiplexed digits (1..8)
//   STABLE_CYCLES   clocks a pattern must hold before it is captured (1..255)
//   SEG_ACTIVE_LOW  1: segment inputs are inverted before decoding
//   EN_ACTIVE_LOW   1: digit_enable inputs are inverted before use
//
// Ports:
//   clock         system clock; all logic runs on the rising edge
//   reset         asynchronous, active-high reset
//   segments      segment bus, bit6 = a .. bit0 = g
//   digit_enable  digit select; one-hot when valid
//   value         decoded nibbles; digit i is in bits [4i+3:4i]
//   digit_valid   per digit: the last capture was a hex pattern
//   digit_error   per digit: the last capture was neither hex nor blank
//   update        one-cycle pulse on any capture
//   frame_done    one-cycle pulse when every digit has been captured
// ============================================================================
module seven_segment_scan_decoder #(
    parameter int DIGITS         = 4,
    parameter int STABLE_CYCLES  = 4,
    parameter bit SEG_ACTIVE_LOW = 1'b0,
    parameter bit EN_ACTIVE_LOW  = 1'b0
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [6:0]            segments,
    input  logic [DIGITS-1:0]     digit_enable,
    output logic [4*DIGITS-1:0]   value,
    output logic [DIGITS-1:0]     digit_valid,
    output logic [DIGITS-1:0]     digit_error,
    output logic                  update,
    output logic                  frame_done
);

    localparam int               RUN_W   = 8;
    localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(STABLE_CYCLES);

    // ------------------------------------------------------------------
    // Pattern decode. Returns {is_hex, nibble}. Any pattern that is not
    // in the table returns is_hex = 0.
    // ------------------------------------------------------------------
    function automatic logic [4:0] decode_hex(input logic [6:0] pat);
        logic [4:0] res;
        res = 5'b0_0000;
        case (pat)
            7'b1111110: res = 5'h10;
            7'b0110000: res = 5'h11;
            7'b1101101: res = 5'h12;
            7'b1111001: res = 5'h13;
            7'b0110011: res = 5'h14;
            7'b1011011: res = 5'h15;
            7'b1011111: res = 5'h16;
            7'b1110000: res = 5'h17;
            7'b1111111: res = 5'h18;
            7'b1111011: res = 5'h19;
            7'b1110111: res = 5'h1A;
            7'b0011111: res = 5'h1B;
            7'b1001110: res = 5'h1C;
            7'b0111101: res = 5'h1D;
            7'b1001111: res = 5'h1E;
            7'b1000111: res = 5'h1F;
            default:    res = 5'b0_0000;
        endcase
        return res;
    endfunction

    // ------------------------------------------------------------------
    // Input synchroniser (raw polarity).
    // ------------------------------------------------------------------
    logic [6:0]        seg_meta_reg;
    logic [6:0]        seg_sync_reg;
    logic [DIGITS-1:0] en_meta_reg;
    logic [DIGITS-1:0] en_sync_reg;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            seg_meta_reg <= '0;
            seg_sync_reg <= '0;
            en_meta_reg  <= '0;
            en_sync_reg  <= '0;
        end else begin
            seg_meta_reg <= segments;
            seg_sync_reg <= seg_meta_reg;
            en_meta_reg  <= digit_enable;
            en_sync_reg  <= en_meta_reg;
        end
    end

    // Polarity-corrected view: 1 = lit / selected.
    logic [6:0]        seg_cur;
    logic [DIGITS-1:0] en_cur;

    assign seg_cur = seg_sync_reg ^ {7{SEG_ACTIVE_LOW}};
    assign en_cur  = en_sync_reg ^ {DIGITS{EN_ACTIVE_LOW}};

    // ------------------------------------------------------------------
    // Stability tracking. The previous corrected pair is stored so that the
    // run counter can restart on any change of either the enable or the
    // segment bus.
    // ------------------------------------------------------------------
    logic [6:0]        seg_last_reg;
    logic [DIGITS-1:0] en_last_reg;
    logic [RUN_W-1:0]  run_reg;
    logic [RUN_W-1:0]  run_next;
    logic              pattern_changed;
    logic              run_reached;
    logic              en_onehot;
    logic              capture;

    assign pattern_changed = ({en_cur, seg_cur} != {en_last_reg, seg_last_reg});

    // x & (x-1) clears the lowest set bit, so the result is zero only when
    // at most one bit was set.
    assign en_onehot = (en_cur != '0) &&
                       ((en_cur & (en_cur - DIGITS'(1))) == '0);

    always_comb begin
        run_next    = run_reg;
        run_reached = 1'b0;
        if (pattern_changed) begin
            run_next = RUN_W'(1);
        end else if (run_reg != RUN_MAX) begin
            run_next = run_reg + RUN_W'(1);
        end
        // Only the clock where the run first arrives at the threshold counts.
        // When STABLE_CYCLES is 1, a change itself is that arrival, even if
        // the previous run was already saturated.
        run_reached = (run_next == RUN_MAX) &&
                      (pattern_changed || (run_reg != RUN_MAX));
    end

    // A run that reaches the threshold while not one-hot is simply lost:
    // once the counter saturates it never reaches the threshold again.
    assign capture = run_reached && en_onehot;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            seg_last_reg <= '0;
            en_last_reg  <= '0;
            run_reg      <= '0;
        end else begin
            seg_last_reg <= seg_cur;
            en_last_reg  <= en_cur;
            run_reg      <= run_next;
        end
    end

    // ------------------------------------------------------------------
    // Shared decode of the currently stable pattern.
    // ------------------------------------------------------------------
    logic [4:0] decoded;
    logic       pat_is_hex;
    logic       pat_is_blank;

    assign decoded      = decode_hex(seg_cur);
    assign pat_is_hex   = decoded[4];
    assign pat_is_blank = (seg_cur == 7'b000_0000);

    // ------------------------------------------------------------------
    // Frame tracking. The capture that completes a frame clears the mask
    // instead of setting its bit, so it does not count toward the next frame.
    // ------------------------------------------------------------------
    logic [DIGITS-1:0] seen_reg;
    logic [DIGITS-1:0] seen_or;
    logic [DIGITS-1:0] seen_next;
    logic              frame_complete;
    logic              update_reg;
    logic              frame_done_reg;

    always_comb begin
        seen_or        = seen_reg;
        frame_complete = 1'b0;
        seen_next      = seen_reg;
        if (capture) begin
            seen_or = seen_reg | en_cur;
        end
        frame_complete = capture && (seen_or == {DIGITS{1'b1}});
        seen_next      = frame_complete ? '0 : seen_or;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            seen_reg       <= '0;
            update_reg     <= 1'b0;
            frame_done_reg <= 1'b0;
        end else begin
            seen_reg       <= seen_next;
            update_reg     <= capture;
            frame_done_reg <= frame_complete;
        end
    end

    assign update     = update_reg;
    assign frame_done = frame_done_reg;

    // ------------------------------------------------------------------
    // Per-digit result registers. A digit changes only when it is the one
    // selected by the capturing enable. A blank or error pattern leaves the
    // last good nibble in place.
    // ------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < DIGITS; gi++) begin : g_digit
            logic [3:0] nibble_reg;
            logic       valid_reg;
            logic       error_reg;
            logic       hit;

            assign hit = capture && en_cur[gi];

            always_ff @(posedge clock or posedge reset) begin
                if (reset) begin
                    nibble_reg <= 4'h0;
                    valid_reg  <= 1'b0;
                    error_reg  <= 1'b0;
                end else if (hit) begin
                    if (pat_is_hex) begin
                        nibble_reg <= decoded[3:0];
                        valid_reg  <= 1'b1;
                        error_reg  <= 1'b0;
                    end else begin
                        valid_reg  <= 1'b0;
                        error_reg  <= !pat_is_blank;
                    end
                end
            end

            assign value[4*gi +: 4] = nibble_reg;
            assign digit_valid[gi]  = valid_reg;
            assign digit_error[gi]  = error_reg;
        end
    endgenerate

endmodule

// File: tb/tb_seven_segment_scan_decoder.sv
module tb_seven_segment_scan_decoder;

    localparam int DIGITS = 4;
    localparam int STABLE = 4;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [6:0]  segments = 7'h00;
    logic [3:0]  digit_enable = 4'h0;
    logic [15:0] value;
    logic [3:0]  digit_valid;
    logic [3:0]  digit_error;
    logic        update;
    logic        frame_done;

    always #5 clock = ~clock;

    seven_segment_scan_decoder #(
        .DIGITS(DIGITS),
        .STABLE_CYCLES(STABLE),
        .SEG_ACTIVE_LOW(1'b0),
        .EN_ACTIVE_LOW(1'b0)
    ) dut (
        .clock(clock),
        .reset(reset),
        .segments(segments),
        .digit_enable(digit_enable),
        .value(value),
        .digit_valid(digit_valid),
        .digit_error(digit_error),
        .update(update),
        .frame_done(frame_done)
    );

    // Segment pattern for each hex digit, a..g.
    logic [6:0] hex_pat [16] = '{
        7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
        7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
        7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
        7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111
    };

    int checks   = 0;
    int failures = 0;

    // ---------------- reference model ----------------
    // Model rule: a capture is decided once the raw input has stayed
    // identical for STABLE sampled edges, and the enable is one-hot. The
    // result becomes visible two edges later, which is the synchroniser
    // delay.
    logic [3:0]  m_value [4];
    logic [3:0]  m_valid, m_error, m_seen;
    logic        m_upd, m_fd;
    logic [10:0] m_prev;
    int          m_run;
    logic        c1_v, c2_v;
    logic [3:0]  c1_en, c2_en;
    logic [6:0]  c1_seg, c2_seg;

    task automatic model_reset();
        for (int i = 0; i < 4; i++) m_value[i] = 4'h0;
        m_valid = '0; m_error = '0; m_seen = '0;
        m_upd = 1'b0; m_fd = 1'b0;
        m_prev = '0; m_run = 0;
        c1_v = 1'b0; c2_v = 1'b0;
        c1_en = '0; c2_en = '0; c1_seg = '0; c2_seg = '0;
    endtask

    task automatic model_apply(input logic [3:0] en, input logic [6:0] seg);
        int d;
        int hx;
        d = 0;
        hx = -1;
        for (int i = 0; i < 4; i++) if (en[i]) d = i;
        for (int i = 0; i < 16; i++) if (hex_pat[i] == seg) hx = i;
        if (hx >= 0) begin
            m_value[d] = 4'(hx);
            m_valid[d] = 1'b1;
            m_error[d] = 1'b0;
        end else begin
            m_valid[d] = 1'b0;
            m_error[d] = (seg != 7'h00);
        end
        m_upd = 1'b1;
        m_seen[d] = 1'b1;
        if (m_seen == 4'hF) begin
            m_fd = 1'b1;
            m_seen = 4'h0;
        end
    endtask

    task automatic model_edge(input logic [3:0] en, input logic [6:0] seg);
        logic changed;
        int   old_run;
        m_upd = 1'b0;
        m_fd  = 1'b0;
        if (c2_v) model_apply(c2_en, c2_seg);
        c2_v = c1_v; c2_en = c1_en; c2_seg = c1_seg;
        changed = ({en, seg} != m_prev);
        old_run = m_run;
        if (changed) m_run = 1;
        else if (m_run < STABLE) m_run++;
        c1_v   = (m_run == STABLE) && (changed || old_run < STABLE) &&
                 ($countones(en) == 1);
        c1_en  = en;
        c1_seg = seg;
        m_prev = {en, seg};
    endtask

    // ---------------- checking ----------------
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic compare_all();
        logic [15:0] ev;
        for (int d = 0; d < 4; d++) ev[4*d +: 4] = m_value[d];
        chk("value", 32'(value), 32'(ev));
        chk("digit_valid", 32'(digit_valid), 32'(m_valid));
        chk("digit_error", 32'(digit_error), 32'(m_error));
        chk("update", 32'(update), 32'(m_upd));
        chk("frame_done", 32'(frame_done), 32'(m_fd));
    endtask

    task automatic step();
        @(posedge clock);
        if (reset) model_reset();
        else model_edge(digit_enable, segments);
        #1;
        compare_all();
    endtask

    // Drive a pattern for n edges. Report how many update and frame_done
    // pulses were seen, and the step index (1 = first edge) of the first
    // update.
    task automatic hold(input logic [3:0] en, input logic [6:0] seg, input int n,
                        output int upd_cnt, output int fd_cnt, output int first_upd);
        digit_enable = en;
        segments     = seg;
        upd_cnt = 0; fd_cnt = 0; first_upd = -1;
        for (int k = 1; k <= n; k++) begin
            step();
            if (update === 1'b1) begin
                upd_cnt++;
                if (first_upd < 0) first_upd = k;
            end
            if (frame_done === 1'b1) fd_cnt++;
        end
    endtask

    initial begin
        int u, f, fu, fd_sum;
        logic [15:0] exp_val;
        logic [3:0]  ren;
        logic [6:0]  rseg;
        int          r;

        model_reset();

        // 1. Reset held with arbitrary inputs, then released while idle.
        for (int k = 0; k < 3; k++) begin
            digit_enable = 4'($urandom);
            segments     = 7'($urandom);
            step();
        end
        chk("reset_value", 32'(value), 32'h0);
        chk("reset_flags", 32'({digit_valid, digit_error, update, frame_done}), 32'h0);
        reset = 1'b0;
        hold(4'h0, 7'h00, 10, u, f, fu);
        chk("idle_no_update", 32'(u), 32'd0);

        // 2. Single digit 2 on position 1; expect exactly one update at E0+5.
        hold(4'b0010, 7'b1101101, 12, u, f, fu);
        chk("tp2_upd_count", 32'(u), 32'd1);
        chk("tp2_latency", 32'(fu), 32'd6);
        chk("tp2_nibble", 32'(value[7:4]), 32'h2);
        chk("tp2_valid", 32'(digit_valid), 32'b0010);

        // 3. A short run is ignored; the following full run is captured.
        hold(4'b0001, 7'b0110000, 3, u, f, fu);
        chk("tp3_short_no_upd", 32'(u), 32'd0);
        hold(4'b0001, 7'b1111110, 8, u, f, fu);
        chk("tp3_upd_count", 32'(u), 32'd1);
        chk("tp3_latency", 32'(fu), 32'd6);
        chk("tp3_nibble", 32'(value[3:0]), 32'h0);

        // 4. Scan C,3,5,A; frame_done comes only with digit 3.
        fd_sum = 0;
        for (int d = 0; d < 4; d++) begin
            hold(4'(1 << d), hex_pat[(d == 0) ? 12 : (d == 1) ? 3 : (d == 2) ? 5 : 10], 8, u, f, fu);
            if (d < 3) fd_sum += f;
            else chk("tp4_fd_digit3", 32'(f), 32'd1);
            hold(4'h0, 7'h00, 1, u, f, fu);
            fd_sum += f;
        end
        chk("tp4_fd_early", 32'(fd_sum), 32'd0);
        chk("tp4_value", 32'(value), 32'hA53C);
        chk("tp4_valid", 32'(digit_valid), 32'hF);
        // Step through all 16 patterns across four frames.
        for (int fr = 0; fr < 4; fr++) begin
            fd_sum = 0;
            for (int d = 0; d < 4; d++) begin
                hold(4'(1 << d), hex_pat[4*fr + d], 8, u, f, fu);
                fd_sum += f;
                exp_val[4*d +: 4] = 4'(4*fr + d);
                hold(4'h0, 7'h00, 1, u, f, fu);
                fd_sum += f;
            end
            chk("tp4_frame_value", 32'(value), 32'(exp_val));
            chk("tp4_frame_fd", 32'(fd_sum), 32'd1);
        end

        // 5. Error pattern and blank both keep the last good nibble.
        hold(4'b0001, hex_pat[7], 8, u, f, fu);
        hold(4'b0001, 7'b1010101, 8, u, f, fu);
        chk("tp5_err_error", 32'(digit_error[0]), 32'd1);
        chk("tp5_err_valid", 32'(digit_valid[0]), 32'd0);
        chk("tp5_err_nibble", 32'(value[3:0]), 32'h7);
        hold(4'b0001, 7'b0000000, 8, u, f, fu);
        chk("tp5_blank_error", 32'(digit_error[0]), 32'd0);
        chk("tp5_blank_valid", 32'(digit_valid[0]), 32'd0);
        chk("tp5_blank_nibble", 32'(value[3:0]), 32'h7);

        // 6. A multi-hot enable is never captured; then reset hits mid-run.
        hold(4'b0110, hex_pat[3], 10, u, f, fu);
        chk("tp6_multihot", 32'(u), 32'd0);
        hold(4'b0100, hex_pat[3], 3, u, f, fu);
        #2;
        reset = 1'b1;
        #1;
        model_reset();
        chk("tp6_async_value", 32'(value), 32'h0);
        chk("tp6_async_flags", 32'({digit_valid, digit_error, update, frame_done}), 32'h0);
        step();
        reset = 1'b0;
        hold(4'b0100, hex_pat[3], 8, u, f, fu);
        chk("tp6_post_rst_latency", 32'(fu), 32'd6);
        chk("tp6_post_rst_count", 32'(u), 32'd1);
        chk("tp6_nibble", 32'(value[11:8]), 32'h3);

        // Random scan traffic checked cycle by cycle against the model.
        for (int it = 0; it < 250; it++) begin
            r = $urandom_range(0, 9);
            if (r < 7) ren = 4'(1 << $urandom_range(0, 3));
            else if (r == 7) ren = 4'h0;
            else ren = 4'($urandom);
            r = $urandom_range(0, 9);
            if (r < 6) rseg = hex_pat[$urandom_range(0, 15)];
            else if (r == 6) rseg = 7'h00;
            else rseg = 7'($urandom);
            hold(ren, rseg, $urandom_range(1, 9), u, f, fu);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
